// File: rtl/sdio_data_pkg.sv
// Shared types and helpers for the SDIO data engine.
package sdio_data_pkg;

  localparam int unsigned BLK_BYTES  = 512;
  localparam int unsigned BYTE_CNT_W = 10;  // holds 1..512

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_FILL,
    ST_TX_STREAM,
    ST_TX_DRAIN,
    ST_RX_STREAM,
    ST_RX_STATUS
  } state_e;

  // A block size field of zero encodes a full 512-byte block.
  function automatic logic [BYTE_CNT_W-1:0] decode_byte_count(input logic [8:0] cnt);
    return (cnt == 9'd0) ? BYTE_CNT_W'(BLK_BYTES) : BYTE_CNT_W'(cnt);
  endfunction

endpackage

// File: rtl/sdio_byte_fifo.sv
// First-word-fall-through byte FIFO with synchronous flush.
module sdio_byte_fifo #(
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_en, pop_en;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign level = level_q;
  // An empty FIFO pushed and popped together hands the incoming byte straight through.
  assign dout  = empty ? din : mem_q[rd_ptr_q];

  // Pointer and level update; push at full / pop at empty allowed when paired.
  always_comb begin
    push_en  = push & (~full | pop);
    pop_en   = pop & (~empty | push);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_en && !pop_en)      level_d = level_q + (AW+1)'(1);
      else if (pop_en && !push_en) level_d = level_q - (AW+1)'(1);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push_en && !flush) mem_q[wr_ptr_q] <= din;
  end

  // Pointer and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/sdio_data_engine.sv
// SDIO DAT-line data engine: moves blocks between the user byte port and the DAT streamers.
module sdio_data_engine
  import sdio_data_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned BLK_CNT_W  = 9
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start_tx,
  input  logic                 start_rx,
  input  logic [8:0]           byte_count,
  input  logic [BLK_CNT_W-1:0] block_count,
  input  logic                 abort,
  input  logic [7:0]           tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 str_start_write,
  input  logic                 str_data_req,
  output logic [7:0]           str_data,
  output logic                 str_data_strobe,
  output logic                 str_data_empty,
  input  logic                 str_tx_busy,
  input  logic                 str_byte_strobe,
  input  logic [7:0]           str_byte,
  input  logic                 str_all_strobe,
  input  logic                 str_crc_ok,
  output logic                 str_crc_status_start,
  output logic                 str_crc_status,
  output logic                 busy,
  output logic                 block_done,
  output logic                 error,
  output logic [BLK_CNT_W-1:0] blocks_left
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_e                 state_q, state_d;
  logic [BYTE_CNT_W-1:0]  bytes_q, bytes_d;
  logic [BYTE_CNT_W-1:0]  bytes_left_q, bytes_left_d;
  logic [BYTE_CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [BLK_CNT_W-1:0]   blocks_q, blocks_d;
  logic                   inf_q, inf_d;
  logic                   ovf_q, ovf_d;
  logic                   error_q, error_d;
  logic                   after_rx_q, after_rx_d;
  logic                   busy_q, busy_d;
  logic [7:0]             str_data_q, str_data_d;
  logic                   str_data_empty_q, str_data_empty_d;
  logic                   str_start_write_q, str_start_write_d;
  logic                   str_data_strobe_q, str_data_strobe_d;
  logic                   crc_start_q, crc_start_d;
  logic                   crc_status_q, crc_status_d;
  logic                   block_done_q, block_done_d;
  logic                   tx_busy_prev_q;
  logic                   out_en_q;

  logic                   fifo_flush, fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [7:0]             fifo_din, fifo_dout;
  logic [LVL_W-1:0]       fifo_level, fill_next;
  logic                   tx_push, tx_pop, rx_push, rx_pop;
  logic                   tx_side, rx_side, last_blk;

  // User-side handshakes derived from FIFO status and the active direction.
  assign tx_side   = state_q inside {ST_IDLE, ST_TX_FILL, ST_TX_STREAM, ST_TX_DRAIN};
  assign rx_side   = (state_q inside {ST_RX_STREAM, ST_RX_STATUS}) |
                     ((state_q == ST_IDLE) & after_rx_q);
  assign tx_ready  = out_en_q & ~fifo_full & tx_side;
  assign tx_push   = tx_valid & tx_ready;
  assign rx_valid  = ~fifo_empty & rx_side;
  assign rx_pop    = rx_valid & rx_ready;
  assign rx_data   = rx_valid ? fifo_dout : 8'h00;
  assign fifo_push = tx_push | rx_push;
  assign fifo_pop  = tx_pop | rx_pop;
  assign fifo_din  = rx_push ? str_byte : tx_data;
  assign fill_next = fifo_level + LVL_W'(tx_push);
  assign last_blk  = ~inf_q & (blocks_q <= BLK_CNT_W'(1));

  sdio_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clock),
    .rst_n (reset_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  // Next-state and output decode; abort overrides everything at the end.
  always_comb begin
    state_d           = state_q;
    bytes_d           = bytes_q;
    bytes_left_d      = bytes_left_q;
    rx_cnt_d          = rx_cnt_q;
    blocks_d          = blocks_q;
    inf_d             = inf_q;
    ovf_d             = ovf_q;
    error_d           = error_q;
    after_rx_d        = after_rx_q;
    str_data_d        = str_data_q;
    str_data_empty_d  = str_data_empty_q;
    str_start_write_d = 1'b0;
    str_data_strobe_d = 1'b0;
    crc_start_d       = 1'b0;
    crc_status_d      = 1'b0;
    block_done_d      = 1'b0;
    fifo_flush        = 1'b0;
    tx_pop            = 1'b0;
    rx_push           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_tx || start_rx) begin
          fifo_flush = 1'b1;
          error_d    = 1'b0;
          bytes_d    = decode_byte_count(byte_count);
          blocks_d   = block_count;
          inf_d      = (block_count == '0);
          after_rx_d = start_rx;
          rx_cnt_d   = '0;
          ovf_d      = 1'b0;
          state_d    = start_rx ? ST_RX_STREAM : ST_TX_FILL;
        end
      end
      ST_TX_FILL: begin
        if (fill_next >= LVL_W'(bytes_q)) begin
          str_start_write_d = 1'b1;
          str_data_empty_d  = 1'b0;
          bytes_left_d      = bytes_q;
          state_d           = ST_TX_STREAM;
        end
      end
      ST_TX_STREAM: begin
        if (str_data_req) begin
          if (bytes_left_q != '0) begin
            tx_pop            = 1'b1;
            str_data_d        = fifo_dout;
            str_data_strobe_d = 1'b1;
            bytes_left_d      = bytes_left_q - BYTE_CNT_W'(1);
          end else begin
            str_data_empty_d = 1'b1;
            state_d          = ST_TX_DRAIN;
          end
        end
      end
      ST_TX_DRAIN: begin
        if (tx_busy_prev_q && !str_tx_busy) begin
          block_done_d = 1'b1;
          if (last_blk) begin
            blocks_d = '0;
            state_d  = ST_IDLE;
          end else begin
            if (!inf_q) blocks_d = blocks_q - BLK_CNT_W'(1);
            state_d = ST_TX_FILL;
          end
        end
      end
      ST_RX_STREAM: begin
        if (str_byte_strobe) begin
          if (rx_cnt_q < bytes_q) begin
            rx_cnt_d = rx_cnt_q + BYTE_CNT_W'(1);
            if (!fifo_full || rx_pop) rx_push = 1'b1;
            else                      ovf_d   = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (str_all_strobe) state_d = ST_RX_STATUS;
      end
      ST_RX_STATUS: begin
        crc_start_d  = 1'b1;
        crc_status_d = str_crc_ok & ~ovf_q & (rx_cnt_q == bytes_q);
        if (!crc_status_d) error_d = 1'b1;
        block_done_d = 1'b1;
        rx_cnt_d     = '0;
        ovf_d        = 1'b0;
        if (last_blk) begin
          blocks_d = '0;
          state_d  = ST_IDLE;
        end else begin
          if (!inf_q) blocks_d = blocks_q - BLK_CNT_W'(1);
          state_d = ST_RX_STREAM;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d           = ST_IDLE;
      fifo_flush        = 1'b1;
      str_data_empty_d  = 1'b1;
      blocks_d          = '0;
      block_done_d      = 1'b0;
      str_start_write_d = 1'b0;
      str_data_strobe_d = 1'b0;
      crc_start_d       = 1'b0;
      crc_status_d      = 1'b0;
      tx_pop            = 1'b0;
      rx_push           = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_IDLE;
      bytes_q           <= '0;
      bytes_left_q      <= '0;
      rx_cnt_q          <= '0;
      blocks_q          <= '0;
      inf_q             <= 1'b0;
      ovf_q             <= 1'b0;
      error_q           <= 1'b0;
      after_rx_q        <= 1'b0;
      busy_q            <= 1'b0;
      str_data_q        <= 8'h00;
      str_data_empty_q  <= 1'b1;
      str_start_write_q <= 1'b0;
      str_data_strobe_q <= 1'b0;
      crc_start_q       <= 1'b0;
      crc_status_q      <= 1'b0;
      block_done_q      <= 1'b0;
      tx_busy_prev_q    <= 1'b0;
      out_en_q          <= 1'b0;
    end else begin
      state_q           <= state_d;
      bytes_q           <= bytes_d;
      bytes_left_q      <= bytes_left_d;
      rx_cnt_q          <= rx_cnt_d;
      blocks_q          <= blocks_d;
      inf_q             <= inf_d;
      ovf_q             <= ovf_d;
      error_q           <= error_d;
      after_rx_q        <= after_rx_d;
      busy_q            <= busy_d;
      str_data_q        <= str_data_d;
      str_data_empty_q  <= str_data_empty_d;
      str_start_write_q <= str_start_write_d;
      str_data_strobe_q <= str_data_strobe_d;
      crc_start_q       <= crc_start_d;
      crc_status_q      <= crc_status_d;
      block_done_q      <= block_done_d;
      tx_busy_prev_q    <= str_tx_busy;
      out_en_q          <= 1'b1;
    end
  end

  assign str_start_write      = str_start_write_q;
  assign str_data             = str_data_q;
  assign str_data_strobe      = str_data_strobe_q;
  assign str_data_empty       = str_data_empty_q;
  assign str_crc_status_start = crc_start_q;
  assign str_crc_status       = crc_status_q;
  assign busy                 = busy_q;
  assign block_done           = block_done_q;
  assign error                = error_q;
  assign blocks_left          = blocks_q;

endmodule

// File: tb/tb_sdio_data_engine.sv
// Directed self-checking bench for sdio_data_engine.
module tb_sdio_data_engine;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       start_tx, start_rx, abort;
  logic [8:0] byte_count, block_count;
  logic [7:0] tx_data, rx_data, str_data, str_byte;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;
  logic       str_start_write, str_data_req, str_data_strobe, str_data_empty, str_tx_busy;
  logic       str_byte_strobe, str_all_strobe, str_crc_ok, str_crc_status_start, str_crc_status;
  logic       busy, block_done, error;
  logic [8:0] blocks_left;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  sdio_data_engine #(.FIFO_DEPTH(512), .BLK_CNT_W(9)) dut (
    .clock(clock), .reset_n(reset_n), .start_tx(start_tx), .start_rx(start_rx),
    .byte_count(byte_count), .block_count(block_count), .abort(abort),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .str_start_write(str_start_write), .str_data_req(str_data_req), .str_data(str_data),
    .str_data_strobe(str_data_strobe), .str_data_empty(str_data_empty), .str_tx_busy(str_tx_busy),
    .str_byte_strobe(str_byte_strobe), .str_byte(str_byte), .str_all_strobe(str_all_strobe),
    .str_crc_ok(str_crc_ok), .str_crc_status_start(str_crc_status_start),
    .str_crc_status(str_crc_status), .busy(busy), .block_done(block_done), .error(error),
    .blocks_left(blocks_left)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One receive block of n bytes starting at value b0, then the status cycle.
  task automatic rx_block(input int n, input logic [7:0] b0);
    for (int i = 0; i < n; i++) begin
      str_byte_strobe = 1'b1;
      str_byte        = b0 + 8'(i);
      tick();
    end
    str_byte_strobe = 1'b0;
    str_all_strobe  = 1'b1;
    tick();
    str_all_strobe  = 1'b0;
    tick();
  endtask

  initial begin
    start_tx = 0; start_rx = 0; abort = 0; byte_count = 0; block_count = 0;
    tx_data = 0; tx_valid = 0; rx_ready = 0; str_data_req = 0; str_tx_busy = 0;
    str_byte_strobe = 0; str_byte = 0; str_all_strobe = 0; str_crc_ok = 0;

    // Reset values
    #1 reset_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_empty", 32'(str_data_empty), 1);
    chk("rst_error", 32'(error), 0);
    chk("rst_blocks_left", 32'(blocks_left), 0);
    chk("rst_tx_ready", 32'(tx_ready), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("idle_tx_ready", 32'(tx_ready), 1);

    // Two 4-byte TX blocks
    byte_count = 9'd4; block_count = 9'd2; start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    chk("tx_busy", 32'(busy), 1);
    chk("tx_blocks_left", 32'(blocks_left), 2);
    for (int i = 0; i < 8; i++) begin
      tx_data = 8'h10 + 8'(i); tx_valid = 1'b1;
      tick();
      if (i == 2) chk("tx_no_start_3_bytes", 32'(str_start_write), 0);
      if (i == 3) begin
        chk("tx_start_after_4th", 32'(str_start_write), 1);
        chk("tx_empty_clear", 32'(str_data_empty), 0);
      end
    end
    tx_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      if (b == 1) begin
        tick();
        chk("tx_start_blk2", 32'(str_start_write), 1);
      end
      str_tx_busy = 1'b1; str_data_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
        tick();
        chk("tx_strobe", 32'(str_data_strobe), 1);
        chk("tx_data", 32'(str_data), 32'(8'h10 + 8'(4*b + k)));
      end
      tick();
      str_data_req = 1'b0;
      chk("tx_data_empty", 32'(str_data_empty), 1);
      chk("tx_no_extra_strobe", 32'(str_data_strobe), 0);
      str_tx_busy = 1'b0;
      tick();
      chk("tx_block_done", 32'(block_done), 1);
      chk("tx_blocks_left_dec", 32'(blocks_left), 32'(1 - b));
      chk("tx_busy_after_blk", 32'(busy), 32'(1 - b));
    end

    // RX block, good CRC
    byte_count = 9'd2; block_count = 9'd1; str_crc_ok = 1'b1; start_rx = 1'b1;
    tick();
    start_rx = 1'b0;
    chk("rx_busy", 32'(busy), 1);
    chk("rx_valid_empty", 32'(rx_valid), 0);
    str_byte_strobe = 1'b1; str_byte = 8'hAA;
    tick();
    chk("rx_valid_first", 32'(rx_valid), 1);
    chk("rx_data_first", 32'(rx_data), 32'h AA);
    str_byte = 8'h55;
    tick();
    str_byte_strobe = 1'b0; str_all_strobe = 1'b1;
    tick();
    str_all_strobe = 1'b0;
    tick();
    chk("rx_crc_start", 32'(str_crc_status_start), 1);
    chk("rx_crc_status", 32'(str_crc_status), 1);
    chk("rx_block_done", 32'(block_done), 1);
    chk("rx_idle", 32'(busy), 0);
    chk("rx_error", 32'(error), 0);
    rx_ready = 1'b1;
    chk("rx_read0", 32'(rx_data), 32'h AA);
    tick();
    chk("rx_read1", 32'(rx_data), 32'h 55);
    tick();
    chk("rx_drained", 32'(rx_valid), 0);
    rx_ready = 1'b0;

    // RX block, bad CRC
    byte_count = 9'd1; block_count = 9'd1; str_crc_ok = 1'b0; start_rx = 1'b1;
    tick();
    start_rx = 1'b0;
    rx_block(1, 8'h3C);
    chk("crcbad_start", 32'(str_crc_status_start), 1);
    chk("crcbad_status", 32'(str_crc_status), 0);
    chk("crcbad_error", 32'(error), 1);
    chk("crcbad_block_done", 32'(block_done), 1);
    tick();
    chk("crcbad_error_sticky", 32'(error), 1);

    // RX block, good CRC but one byte too many
    str_crc_ok = 1'b1; start_rx = 1'b1;
    tick();
    start_rx = 1'b0;
    chk("ovf_error_cleared", 32'(error), 0);
    rx_block(2, 8'h01);
    chk("ovf_status", 32'(str_crc_status), 0);
    chk("ovf_error", 32'(error), 1);

    // Infinite RX: three blocks, stray start_tx ignored, then abort
    byte_count = 9'd2; block_count = 9'd0; start_rx = 1'b1;
    tick();
    start_rx = 1'b0;
    for (int b = 0; b < 3; b++) begin
      if (b == 1) start_tx = 1'b1;
      str_byte_strobe = 1'b1; str_byte = 8'(b);
      tick();
      start_tx = 1'b0;
      chk("inf_no_done_mid", 32'(block_done), 0);
      str_byte = 8'(b) + 8'h80;
      tick();
      str_byte_strobe = 1'b0; str_all_strobe = 1'b1;
      tick();
      str_all_strobe = 1'b0;
      tick();
      chk("inf_block_done", 32'(block_done), 1);
      chk("inf_blocks_left", 32'(blocks_left), 0);
      chk("inf_busy", 32'(busy), 1);
    end
    chk("inf_rx_valid", 32'(rx_valid), 1);
    str_byte_strobe = 1'b1; str_byte = 8'hEE;
    tick();
    str_byte_strobe = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", 32'(busy), 0);
    chk("abort_flushed", 32'(rx_valid), 0);
    chk("abort_no_done", 32'(block_done), 0);
    chk("abort_blocks_left", 32'(blocks_left), 0);
    chk("abort_data_empty", 32'(str_data_empty), 1);

    // Reset in the middle of TX streaming
    byte_count = 9'd2; block_count = 9'd1; start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    tx_valid = 1'b1; tx_data = 8'hA1;
    tick();
    tx_data = 8'hA2;
    tick();
    tx_valid = 1'b0;
    chk("mid_start", 32'(str_start_write), 1);
    str_tx_busy = 1'b1; str_data_req = 1'b1;
    tick();
    str_data_req = 1'b0;
    chk("mid_strobe", 32'(str_data_strobe), 1);
    chk("mid_data", 32'(str_data), 32'h A1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_strobe", 32'(str_data_strobe), 0);
    chk("arst_data", 32'(str_data), 0);
    chk("arst_empty", 32'(str_data_empty), 1);
    chk("arst_blocks_left", 32'(blocks_left), 0);
    chk("arst_tx_ready", 32'(tx_ready), 0);
    chk("arst_error", 32'(error), 0);
    str_tx_busy = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    tick();
    chk("post_rst_no_done", 32'(block_done), 0);
    chk("post_rst_no_crc", 32'(str_crc_status_start), 0);
    chk("post_rst_idle", 32'(busy), 0);
    chk("post_rst_tx_ready", 32'(tx_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
